race_control: RTL and testbench

- Parametrised game-flow controller for the typing-race datapath, clocked on clk_div.
- Sequences SELECT → COUNTDOWN → INGAME (with PAUSED) → FINISH.
- Supports time-limited and word-count game modes with configurable option tables.
- Owns the seconds prescaler, the remaining-time/word counters, elapsed-time and typed-word statistics, and the saturating volume setting consumed by the audio block.

---
 rtl/race_control.sv | 194 +++++++++++++++++++
 tb/tb_race_control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/race_control.sv
// Game-flow controller for the typing race: option select, countdown, timed/word-count
// play with pause, and finish, plus the seconds prescaler, game statistics and volume.
module race_control #(
  parameter int TICKS_PER_SEC = 10,
  parameter int CD_SECS       = 3,
  parameter int TIME_STEP     = 15,
  parameter int TIME_LEVELS   = 6,
  parameter int WORD_STEP     = 25,
  parameter int WORD_LEVELS   = 4,
  parameter int VAL_W         = 7,
  parameter int VOL_W         = 5,
  parameter int VOL_MAX       = 16,
  parameter int VOL_INIT      = 8,
  parameter int STAT_W        = 10
) (
  input  logic              clk_div,
  input  logic              rst,
  input  logic              start,
  input  logic              sel_up,
  input  logic              sel_down,
  input  logic              vol_up,
  input  logic              vol_down,
  input  logic              pause,
  input  logic              mode,
  input  logic              word_done,
  output logic [2:0]        state,
  output logic              game_mode,
  output logic [VAL_W-1:0]  value,
  output logic [VOL_W-1:0]  vol,
  output logic [STAT_W-1:0] elapsed,
  output logic [STAT_W-1:0] words_typed,
  output logic              game_over
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int CW = $clog2(CD_SECS + 1);
  localparam int TW = (TIME_LEVELS > 1) ? $clog2(TIME_LEVELS) : 1;
  localparam int WW = (WORD_LEVELS > 1) ? $clog2(WORD_LEVELS) : 1;

  typedef enum logic [2:0] {
    S_SELECT    = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_INGAME    = 3'd2,
    S_FINISH    = 3'd3,
    S_PAUSED    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              game_mode_q, game_mode_d;
  logic [TW-1:0]     time_idx_q, time_idx_d;
  logic [WW-1:0]     word_idx_q, word_idx_d;
  logic [VOL_W-1:0]  vol_q, vol_d;
  logic [STAT_W-1:0] elapsed_q, elapsed_d;
  logic [STAT_W-1:0] words_q, words_d;
  logic              game_over_q, game_over_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CW-1:0]     cd_q, cd_d;
  logic [VAL_W-1:0]  remain_q, remain_d;

  logic              sec_pulse;
  logic              dec_remain;
  logic [VAL_W-1:0]  time_tgt, word_tgt, sel_tgt;

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q     <= S_SELECT;
      game_mode_q <= 1'b0;
      time_idx_q  <= '0;
      word_idx_q  <= '0;
      vol_q       <= VOL_W'(VOL_INIT);
      elapsed_q   <= '0;
      words_q     <= '0;
      game_over_q <= 1'b0;
      presc_q     <= '0;
      cd_q        <= '0;
      remain_q    <= '0;
    end else begin
      state_q     <= state_d;
      game_mode_q <= game_mode_d;
      time_idx_q  <= time_idx_d;
      word_idx_q  <= word_idx_d;
      vol_q       <= vol_d;
      elapsed_q   <= elapsed_d;
      words_q     <= words_d;
      game_over_q <= game_over_d;
      presc_q     <= presc_d;
      cd_q        <= cd_d;
      remain_q    <= remain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    game_mode_d = game_mode_q;
    time_idx_d  = time_idx_q;
    word_idx_d  = word_idx_q;
    vol_d       = vol_q;
    elapsed_d   = elapsed_q;
    words_d     = words_q;
    game_over_d = 1'b0;
    presc_d     = presc_q;
    cd_d        = cd_q;
    remain_d    = remain_q;
    dec_remain  = 1'b0;

    time_tgt  = (VAL_W'(time_idx_q) + VAL_W'(1)) * VAL_W'(TIME_STEP);
    word_tgt  = (VAL_W'(word_idx_q) + VAL_W'(1)) * VAL_W'(WORD_STEP);
    sel_tgt   = game_mode_q ? word_tgt : time_tgt;
    sec_pulse = ((state_q == S_COUNTDOWN) || (state_q == S_INGAME)) &&
                (presc_q == PW'(TICKS_PER_SEC - 1));

    unique case (state_q)
      S_SELECT: begin
        presc_d     = '0;
        game_mode_d = mode;
        if (start) begin
          state_d = S_COUNTDOWN;
          cd_d    = CW'(CD_SECS);
        end else if (sel_up != sel_down) begin
          if (mode) begin
            if (sel_up) word_idx_d = (word_idx_q == WW'(WORD_LEVELS - 1)) ? '0 : word_idx_q + WW'(1);
            else        word_idx_d = (word_idx_q == '0) ? WW'(WORD_LEVELS - 1) : word_idx_q - WW'(1);
          end else begin
            if (sel_up) time_idx_d = (time_idx_q == TW'(TIME_LEVELS - 1)) ? '0 : time_idx_q + TW'(1);
            else        time_idx_d = (time_idx_q == '0) ? TW'(TIME_LEVELS - 1) : time_idx_q - TW'(1);
          end
        end
      end
      S_COUNTDOWN: begin
        presc_d = sec_pulse ? '0 : presc_q + PW'(1);
        if (sec_pulse) begin
          if (cd_q == CW'(1)) begin
            state_d   = S_INGAME;
            remain_d  = sel_tgt;
            elapsed_d = '0;
            words_d   = '0;
          end else begin
            cd_d = cd_q - CW'(1);
          end
        end
      end
      S_INGAME: begin
        // A pause press freezes the prescaler on that same cycle, so no tick is lost.
        if (pause) begin
          state_d = S_PAUSED;
        end else begin
          presc_d = sec_pulse ? '0 : presc_q + PW'(1);
          if (sec_pulse && (elapsed_q != '1)) elapsed_d = elapsed_q + STAT_W'(1);
          if (word_done && (words_q != '1))   words_d   = words_q + STAT_W'(1);
          dec_remain = game_mode_q ? word_done : sec_pulse;
          if (dec_remain) begin
            if (remain_q <= VAL_W'(1)) begin
              remain_d    = '0;
              state_d     = S_FINISH;
              game_over_d = 1'b1;
            end else begin
              remain_d = remain_q - VAL_W'(1);
            end
          end
        end
      end
      S_PAUSED: begin
        if (pause) state_d = S_INGAME;
      end
      S_FINISH: begin
        presc_d = '0;
        if (start) state_d = S_SELECT;
      end
      default: begin
        state_d = S_SELECT;
        presc_d = '0;
      end
    endcase

    if (vol_up && !vol_down && (vol_q < VOL_W'(VOL_MAX))) vol_d = vol_q + VOL_W'(1);
    if (vol_down && !vol_up && (vol_q != '0))             vol_d = vol_q - VOL_W'(1);
  end

  always_comb begin
    unique case (state_q)
      S_SELECT:    value = sel_tgt;
      S_COUNTDOWN: value = VAL_W'(cd_q);
      default:     value = remain_q;
    endcase
  end

  assign state       = state_q;
  assign game_mode   = game_mode_q;
  assign vol         = vol_q;
  assign elapsed     = elapsed_q;
  assign words_typed = words_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_race_control.sv
// Directed and randomized checks of race_control against a count-based model of a game.
module tb_race_control;

  logic       clk_div = 1'b0;
  logic       rst, start, sel_up, sel_down, vol_up, vol_down, pause, mode, word_done;
  logic [2:0] state;
  logic       game_mode;
  logic [6:0] value;
  logic [4:0] vol;
  logic [9:0] elapsed, words_typed;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  race_control dut (
    .clk_div(clk_div), .rst(rst), .start(start), .sel_up(sel_up), .sel_down(sel_down),
    .vol_up(vol_up), .vol_down(vol_down), .pause(pause), .mode(mode), .word_done(word_done),
    .state(state), .game_mode(game_mode), .value(value), .vol(vol), .elapsed(elapsed),
    .words_typed(words_typed), .game_over(game_over)
  );

  always #5 clk_div = ~clk_div;

  task automatic step();
    @(posedge clk_div);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int t_idx, w_idx;
    rst = 1'b1; start = 0; sel_up = 0; sel_down = 0; vol_up = 0; vol_down = 0;
    pause = 0; mode = 0; word_done = 0;
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_mode", game_mode, 0);
    chk("rst_value", value, 15);
    chk("rst_vol", vol, 8);
    chk("rst_elapsed", elapsed, 0);
    chk("rst_words", words_typed, 0);
    chk("rst_go", game_over, 0);
    rst = 1'b0;
    step();

    // 45 s time game: countdown timing, pause behaviour, then reset mid-game
    repeat (2) begin sel_up = 1; step(); sel_up = 0; end
    chk("sel45_value", value, 45);
    start = 1; step(); start = 0;
    chk("cd_enter_state", state, 1);
    chk("cd_enter_value", value, 3);
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("cd_state", state, (i < 30) ? 1 : 2);
      chk("cd_value", value, (i < 30) ? (3 - i / 10) : 45);
    end
    repeat (4) step();
    pause = 1; word_done = 1; step(); pause = 0;
    chk("pause_state", state, 4);
    chk("pause_drop_word", words_typed, 0);
    repeat (49) step();
    word_done = 0;
    chk("paused_words", words_typed, 0);
    chk("paused_elapsed", elapsed, 0);
    chk("paused_value", value, 45);
    pause = 1; step(); pause = 0;
    chk("resume_state", state, 2);
    repeat (5) step();
    chk("resume_no_tick", elapsed, 0);
    step();
    chk("resume_tick_elapsed", elapsed, 1);
    chk("resume_tick_value", value, 44);
    repeat (7) step();
    rst = 1'b1; #1;
    chk("midrst_state", state, 0);
    chk("midrst_value", value, 15);
    chk("midrst_vol", vol, 8);
    chk("midrst_go", game_over, 0);
    step();
    chk("midrst_go_hold", game_over, 0);
    rst = 1'b0;
    step();

    // volume saturation
    vol_up = 1; repeat (20) step(); vol_up = 0;
    chk("vol_max", vol, 16);
    vol_down = 1; repeat (20) step(); vol_down = 0;
    chk("vol_min", vol, 0);
    vol_up = 1; vol_down = 1; step(); vol_down = 0;
    chk("vol_both_0", vol, 0);
    step(); vol_up = 0;
    chk("vol_up1", vol, 1);
    vol_up = 1; vol_down = 1; step(); vol_up = 0; vol_down = 0;
    chk("vol_both_1", vol, 1);

    // 15 s time game with no input
    start = 1; step(); start = 0;
    repeat (30) step();
    chk("t15_ingame", state, 2);
    repeat (149) step();
    chk("t15_pre_state", state, 2);
    chk("t15_pre_value", value, 1);
    chk("t15_pre_go", game_over, 0);
    step();
    chk("t15_fin_state", state, 3);
    chk("t15_fin_go", game_over, 1);
    chk("t15_fin_elapsed", elapsed, 15);
    chk("t15_fin_value", value, 0);
    step();
    chk("t15_go_once", game_over, 0);
    chk("t15_hold_elapsed", elapsed, 15);
    start = 1; step(); start = 0;
    chk("t15_back_state", state, 0);
    chk("t15_back_value", value, 15);

    // selection wrap, index hold per mode, word game
    sel_up = 1; step(); sel_up = 0;
    chk("sel_t30", value, 30);
    sel_up = 1; sel_down = 1; step(); sel_up = 0; sel_down = 0;
    chk("sel_both", value, 30);
    mode = 1; step();
    chk("wm_mode", game_mode, 1);
    chk("wm_value", value, 25);
    sel_down = 1; step(); sel_down = 0;
    chk("wm_wrap_down", value, 100);
    sel_up = 1; step(); sel_up = 0;
    chk("wm_wrap_up", value, 25);
    mode = 0; step();
    chk("time_idx_held", value, 30);
    mode = 1; step();
    start = 1; step(); start = 0;
    mode = 0;
    repeat (30) step();
    chk("wg_mode_latched", game_mode, 1);
    chk("wg_state", state, 2);
    chk("wg_value", value, 25);
    word_done = 1;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 24) begin
        chk("wg24_state", state, 2);
        chk("wg24_value", value, 1);
        chk("wg24_words", words_typed, 24);
      end
    end
    word_done = 0;
    chk("wg_fin_state", state, 3);
    chk("wg_fin_go", game_over, 1);
    chk("wg_fin_words", words_typed, 25);
    chk("wg_fin_elapsed", elapsed, 2);
    step();
    chk("wg_go_once", game_over, 0);
    start = 1; step(); start = 0;
    chk("wg_back_state", state, 0);

    // randomized games against a count-based model
    rst = 1'b1; step(); rst = 1'b0; step();
    t_idx = 0; w_idx = 0;
    for (int g = 0; g < 6; g++) begin
      int m, tgt, act, el, wd, rem, cyc;
      bit paused, done, p, w;
      m = $urandom_range(0, 1);
      mode = m[0]; step();
      chk("rnd_mode", game_mode, m);
      for (int k = 0; k < $urandom_range(0, 6); k++) begin
        int r;
        r = $urandom_range(0, 2);
        sel_up = (r != 1); sel_down = (r != 0);
        step();
        sel_up = 0; sel_down = 0;
        if (r == 0) begin
          if (m == 1) w_idx = (w_idx + 1) % 4; else t_idx = (t_idx + 1) % 6;
        end else if (r == 1) begin
          if (m == 1) w_idx = (w_idx + 3) % 4; else t_idx = (t_idx + 5) % 6;
        end
      end
      tgt = (m == 1) ? (w_idx + 1) * 25 : (t_idx + 1) * 15;
      chk("rnd_sel_value", value, tgt);
      start = 1; step(); start = 0;
      repeat (30) step();
      chk("rnd_ingame", state, 2);
      chk("rnd_ingame_value", value, tgt);
      act = 0; el = 0; wd = 0; rem = tgt; cyc = 0; paused = 0; done = 0;
      while (!done && cyc < 3000) begin
        p = ($urandom_range(0, 29) == 0);
        w = (m == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
        pause = p; word_done = w;
        step();
        pause = 0; word_done = 0;
        cyc++;
        if (paused) begin
          if (p) paused = 0;
        end else if (p) begin
          paused = 1;
        end else begin
          act++;
          if (act % 10 == 0) el++;
          if (w) wd++;
          rem = tgt - ((m == 1) ? wd : el);
          if (rem == 0) done = 1;
        end
        chk("rnd_state", state, done ? 3 : (paused ? 4 : 2));
        chk("rnd_value", value, rem);
        chk("rnd_elapsed", elapsed, el);
        chk("rnd_words", words_typed, wd);
        chk("rnd_go", game_over, done);
      end
      chk("rnd_finished", done, 1);
      step();
      chk("rnd_go_once", game_over, 0);
      chk("rnd_fin_hold", state, 3);
      start = 1; step(); start = 0;
      chk("rnd_back_select", state, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
